// File: rtl/sensor_cmd_framer.sv
// UART-to-I2C command framer: parses FF/OP/ADDR/DATA/FF frames into a command FIFO
// and offers either the FIFO head or a round-robin default poll to the I2C controller.
module sensor_cmd_framer #(
    parameter int NUM_SENSORS    = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int SW             = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_byte,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [SW-1:0] cmd_sensor,
    output logic [1:0]    cmd_op,
    output logic [7:0]    cmd_reg_addr,
    output logic [15:0]   cmd_data,
    output logic          cmd_from_pc,
    output logic          fifo_full,
    output logic          time_out,
    output logic          frame_error,
    output logic          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [4:0] NS5 = 5'(NUM_SENSORS);

    typedef struct packed {
        logic [SW-1:0] sensor;
        logic [1:0]    op;
        logic [7:0]    addr;
        logic [15:0]   data;
    } frame_t;

    typedef enum logic [2:0] {IDLE, GET_OP, GET_ADDR, GET_LO, GET_HI, GET_STOP} state_t;

    state_t        state_q;
    frame_t        frm_q;
    logic [TW-1:0] tcnt_q;
    logic          time_out_q, frame_error_q, overflow_q;

    frame_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] poll_q;
    logic          valid_q;

    logic push, do_push, pop, poll_xfer, empty, full;
    frame_t head;

    assign push      = rx_done_tick && (state_q == GET_STOP) && (rx_byte == 8'hFF);
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign pop       = valid_q && cmd_ready && !empty;
    assign poll_xfer = valid_q && cmd_ready && empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push   = push && (!full || pop);
    assign head      = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            frm_q         <= '0;
            tcnt_q        <= '0;
            time_out_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            time_out_q    <= 1'b0;
            frame_error_q <= 1'b0;
            if (rx_done_tick || state_q == IDLE) tcnt_q <= '0;
            else                                 tcnt_q <= tcnt_q + TW'(1);

            if (rx_done_tick) begin
                case (state_q)
                    IDLE: if (rx_byte == 8'hFF) state_q <= GET_OP;
                    GET_OP: begin
                        if (rx_byte[3:2] != 2'b00 || {1'b0, rx_byte[7:4]} >= NS5) begin
                            frame_error_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            frm_q.sensor <= rx_byte[4 +: SW];
                            frm_q.op     <= rx_byte[1:0];
                            frm_q.data   <= '0;
                            state_q      <= GET_ADDR;
                        end
                    end
                    GET_ADDR: begin
                        frm_q.addr <= rx_byte;
                        state_q    <= frm_q.op[1] ? GET_LO : GET_STOP;
                    end
                    GET_LO: begin
                        frm_q.data[7:0] <= rx_byte;
                        state_q         <= frm_q.op[0] ? GET_HI : GET_STOP;
                    end
                    GET_HI: begin
                        frm_q.data[15:8] <= rx_byte;
                        state_q          <= GET_STOP;
                    end
                    GET_STOP: begin
                        if (rx_byte != 8'hFF) frame_error_q <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                time_out_q <= 1'b1;
                state_q    <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem_q[wr_q] <= frm_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            poll_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= 1'b1;
            overflow_q <= push && full && !pop;
            if (do_push) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(pop);
            if (poll_xfer)
                poll_q <= (poll_q == SW'(NUM_SENSORS - 1)) ? '0 : poll_q + SW'(1);
        end
    end

    // payload follows registered FIFO/poll state, so it only moves on a transfer or a push
    always_comb begin
        cmd_valid    = valid_q;
        cmd_sensor   = '0;
        cmd_op       = '0;
        cmd_reg_addr = '0;
        cmd_data     = '0;
        cmd_from_pc  = 1'b0;
        if (valid_q) begin
            if (!empty) begin
                cmd_sensor   = head.sensor;
                cmd_op       = head.op;
                cmd_reg_addr = head.addr;
                cmd_data     = head.data;
                cmd_from_pc  = 1'b1;
            end else begin
                cmd_sensor = poll_q;
                cmd_op     = 2'b01;
            end
        end
    end

    assign fifo_full   = full;
    assign time_out    = time_out_q;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sensor_cmd_framer.sv
// Directed plus randomized bench for sensor_cmd_framer against a queue-based frame model.
module tb_sensor_cmd_framer;
    localparam int NS = 4;
    localparam int D  = 4;
    localparam int T  = 40;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_done_tick = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid, cmd_from_pc, fifo_full, time_out, frame_error, overflow;
    logic [SW-1:0] cmd_sensor;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_reg_addr;
    logic [15:0]   cmd_data;

    int total = 0;
    int bad   = 0;
    int tcount;

    sensor_cmd_framer #(.NUM_SENSORS(NS), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_byte(rx_byte),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sensor(cmd_sensor),
        .cmd_op(cmd_op), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
        .cmd_from_pc(cmd_from_pc), .fifo_full(fifo_full), .time_out(time_out),
        .frame_error(frame_error), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int sensor; int op; int addr; int data; } cmd_t;

    cmd_t       mq[$];
    logic [7:0] m_cur[$];
    int         m_poll = 0;
    int         m_gap = 0;
    bit         m_started = 0;
    bit         m_inframe = 0;
    bit         e_tout = 0, e_ferr = 0, e_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock edge of the reference: bytes build a frame, completed frames go into a queue
    task automatic model_edge(input bit tick, input logic [7:0] b, input bit rdy, input bit rst);
        bit   pop, full_pre, done;
        cmd_t f;
        int   nd;
        e_tout = 0; e_ferr = 0; e_ovf = 0;
        if (!rst) begin
            mq.delete(); m_cur.delete();
            m_inframe = 0; m_gap = 0; m_poll = 0; m_started = 0;
            return;
        end
        pop = 0; done = 0; nd = 0;
        f = '{0, 0, 0, 0};
        full_pre = (mq.size() == D);
        if (m_started && rdy) begin
            if (mq.size() > 0) pop = 1;
            else m_poll = (m_poll + 1) % NS;
        end
        if (tick) begin
            m_gap = 0;
            if (!m_inframe) begin
                if (b == 8'hFF) begin m_inframe = 1; m_cur.delete(); end
            end else begin
                m_cur.push_back(b);
                if (m_cur.size() == 1) begin
                    if (b[3:2] != 2'b00 || int'(b[7:4]) >= NS) begin e_ferr = 1; m_inframe = 0; end
                end else begin
                    nd = m_cur[0][1] ? (m_cur[0][0] ? 2 : 1) : 0;
                    if (m_cur.size() == 3 + nd) begin
                        m_inframe = 0;
                        if (b == 8'hFF) begin
                            done = 1;
                            f.sensor = int'(m_cur[0][7:4]);
                            f.op     = int'(m_cur[0][1:0]);
                            f.addr   = int'(m_cur[1]);
                            f.data   = (nd == 0) ? 0 : (nd == 1) ? int'(m_cur[2])
                                     : int'(m_cur[3]) * 256 + int'(m_cur[2]);
                        end else e_ferr = 1;
                    end
                end
            end
        end else if (m_inframe) begin
            m_gap++;
            if (m_gap == T) begin e_tout = 1; m_inframe = 0; end
        end
        if (pop) void'(mq.pop_front());
        if (done) begin
            if (full_pre && !pop) e_ovf = 1;
            else mq.push_back(f);
        end
        m_started = 1;
    endtask

    task automatic check_outputs();
        int es, eo, ea, ed, ep;
        if (!m_started) begin es = 0; eo = 0; ea = 0; ed = 0; ep = 0; end
        else if (mq.size() > 0) begin
            es = mq[0].sensor; eo = mq[0].op; ea = mq[0].addr; ed = mq[0].data; ep = 1;
        end else begin es = m_poll; eo = 1; ea = 0; ed = 0; ep = 0; end
        chk("cmd_valid",   32'(cmd_valid),    32'(m_started));
        chk("cmd_sensor",  32'(cmd_sensor),   32'(es));
        chk("cmd_op",      32'(cmd_op),       32'(eo));
        chk("cmd_addr",    32'(cmd_reg_addr), 32'(ea));
        chk("cmd_data",    32'(cmd_data),     32'(ed));
        chk("cmd_from_pc", 32'(cmd_from_pc),  32'(ep));
        chk("fifo_full",   32'(fifo_full),    32'(m_started && mq.size() == D));
        chk("time_out",    32'(time_out),     32'(e_tout));
        chk("frame_error", 32'(frame_error),  32'(e_ferr));
        chk("overflow",    32'(overflow),     32'(e_ovf));
    endtask

    task automatic step(input bit tick, input logic [7:0] b, input bit rdy, input bit rst);
        @(negedge clk);
        rx_done_tick = tick; rx_byte = b; cmd_ready = rdy; reset = rst;
        @(posedge clk);
        model_edge(tick, b, rdy, rst);
        #1;
        check_outputs();
    endtask

    function automatic bit rnd_rdy();
        return $urandom_range(0, 2) == 0;
    endfunction

    task automatic rbyte(input logic [7:0] b);
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) step(0, 8'h00, rnd_rdy(), 1);
        step(1, b, rnd_rdy(), 1);
    endtask

    task automatic rand_frame();
        int kind, nd;
        logic [7:0] ob, stopb;
        kind = $urandom_range(0, 9);
        ob = 8'($urandom_range(0, NS - 1) * 16 + $urandom_range(0, 3));
        if (kind == 0) ob[3:2] = 2'($urandom_range(1, 3));
        if (kind == 1) ob[7:4] = 4'($urandom_range(NS, 15));
        stopb = (kind == 2) ? 8'($urandom_range(0, 254)) : 8'hFF;
        if (kind == 3) begin rbyte(8'($urandom_range(0, 254))); return; end
        nd = ob[1] ? (ob[0] ? 2 : 1) : 0;
        rbyte(8'hFF); rbyte(ob); rbyte(8'($urandom));
        for (int i = 0; i < nd; i++) rbyte(8'($urandom));
        if (kind == 4) begin
            for (int i = 0; i < T + 1; i++) step(0, 8'h00, rnd_rdy(), 1);
            return;
        end
        rbyte(stopb);
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(1, b, rdy, 1);
    endtask

    initial begin
        logic [7:0] ob;
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
        chk("reset_valid", 32'(cmd_valid), 32'd0);
        chk("reset_op", 32'(cmd_op), 32'd0);
        step(0, 8'h00, 0, 1);
        chk("valid_after_release", 32'(cmd_valid), 32'd1);

        // default poll round robin with an empty FIFO
        for (int i = 0; i < 5; i++) begin
            chk("poll_seq", 32'(cmd_sensor), 32'(i % NS));
            step(0, 8'h00, 1, 1);
        end

        // write2 frame held while not ready
        send(8'hFF, 0); send(8'h23, 0); send(8'h03, 0);
        send(8'h34, 0); send(8'h12, 0); send(8'hFF, 0);
        step(0, 8'h00, 0, 1);
        chk("w2_sensor", 32'(cmd_sensor), 32'd2);
        chk("w2_op", 32'(cmd_op), 32'd3);
        chk("w2_addr", 32'(cmd_reg_addr), 32'h03);
        chk("w2_data", 32'(cmd_data), 32'h1234);
        chk("w2_from_pc", 32'(cmd_from_pc), 32'd1);
        step(0, 8'h00, 1, 1);

        // bad stop byte, then bad sensor index
        send(8'hFF, 0); send(8'h00, 0); send(8'h02, 0); send(8'hFE, 0);
        chk("bad_stop_ferr", 32'(frame_error), 32'd1);
        chk("bad_stop_nopush", 32'(cmd_from_pc), 32'd0);
        send(8'hFF, 0); send(8'h53, 0);
        chk("bad_sensor_ferr", 32'(frame_error), 32'd1);
        step(0, 8'h00, 0, 1);

        // inter-byte timeout discards the partial frame
        send(8'hFF, 0); send(8'h01, 0);
        tcount = 0;
        for (int i = 0; i < T + 3; i++) begin
            step(0, 8'h00, 0, 1);
            if (time_out === 1'b1) tcount++;
        end
        chk("timeout_pulses", 32'(tcount), 32'd1);
        chk("timeout_nopush", 32'(cmd_from_pc), 32'd0);
        send(8'hFF, 0); send(8'h01, 0); send(8'h05, 0); send(8'hFF, 0);
        chk("after_to_addr", 32'(cmd_reg_addr), 32'h05);
        chk("after_to_pc", 32'(cmd_from_pc), 32'd1);
        step(0, 8'h00, 1, 1);

        // fill FIFO, overflow on one more, drain in order
        for (int k = 0; k <= D; k++) begin
            ob = 8'((k % NS) * 16 + 2);
            send(8'hFF, 0); send(ob, 0); send(8'(k), 0); send(8'(8'hA0 + k), 0); send(8'hFF, 0);
        end
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        for (int k = 0; k < D; k++) begin
            chk("drain_addr", 32'(cmd_reg_addr), 32'(k));
            step(0, 8'h00, 1, 1);
        end
        chk("drain_empty", 32'(cmd_from_pc), 32'd0);

        // reset mid-frame
        send(8'hFF, 0); send(8'h02, 0); send(8'h10, 0);
        step(0, 8'h00, 0, 0);
        chk("midrst_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_data", 32'(cmd_data), 32'd0);
        step(0, 8'h00, 0, 1);
        send(8'hFF, 0); send(8'h01, 0); send(8'h07, 0); send(8'hFF, 0);
        chk("postrst_addr", 32'(cmd_reg_addr), 32'h07);
        chk("postrst_pc", 32'(cmd_from_pc), 32'd1);
        step(0, 8'h00, 1, 1);

        for (int it = 0; it < 200; it++) rand_frame();
        for (int i = 0; i < D + 2; i++) step(0, 8'h00, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sensor_cmd_framer.md
SENSOR_CMD_FRAMER -- requirements
Module: sensor_cmd_framer

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 4, number of addressable sensor channels (1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, instruction FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000_000, which is 10 s at 100 MHz and is the inter-byte timeout.
REQ-004 SHALL have parameter SW = max(1,$clog2(NUM_SENSORS)), which is the sensor index width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1, a synchronous, active-low reset.
REQ-007 SHALL have port rx_done_tick, input, 1, a one-cycle strobe that marks a received UART byte.
REQ-008 SHALL have port rx_byte, input, 8, the received byte, valid when rx_done_tick is high.
REQ-009 SHALL have port cmd_valid, output, 1, meaning a command is offered to the I2C controller.
REQ-010 SHALL have port cmd_ready, input, 1, meaning the I2C controller accepts the command; transfer occurs when cmd_valid and cmd_ready are both high.
REQ-011 SHALL have outputs cmd_sensor (SW), cmd_op (2), cmd_reg_addr (8), cmd_data (16) and cmd_from_pc (1), which form the command payload.
REQ-012 SHALL have outputs fifo_full (1, level), time_out (1, pulse), frame_error (1, pulse) and overflow (1, pulse).

Function
REQ-013 Frame format SHALL be START 0xFF, OP, ADDR, then DATA bytes (0, 1 or 2 per op), then STOP 0xFF.
REQ-014 OP byte fields SHALL be: [1:0] op (00 read1, 01 read2, 10 write1, 11 write2), [3:2] reserved (must be 0), [7:4] sensor index.
REQ-015 FSM states SHALL be IDLE, GET_OP, GET_ADDR, GET_LO, GET_HI, GET_STOP; the FSM advances only on rx_done_tick.
REQ-016 In IDLE, 0xFF SHALL move to GET_OP; any other byte SHALL be ignored silently.
REQ-017 In GET_OP, reserved bits nonzero or sensor index >= NUM_SENSORS SHALL pulse frame_error for 1 cycle and return to IDLE.
REQ-018 From GET_ADDR the FSM SHALL go to GET_STOP for reads, or to GET_LO for writes.
REQ-019 From GET_LO the FSM SHALL go to GET_HI for write2, or to GET_STOP for write1.
REQ-020 Data SHALL arrive LSB first; write1 yields cmd_data = {8'h00, LO}, write2 yields {HI, LO}, and reads yield 16'h0000.
REQ-021 In GET_STOP, a byte of 0xFF SHALL push the frame (cmd_from_pc=1) and go to IDLE; any other value SHALL pulse frame_error, push nothing and go to IDLE.
REQ-022 The timeout counter SHALL clear on every rx_done_tick and while in IDLE.
REQ-023 When the FSM is not in IDLE and the counter reaches TIMEOUT_CYCLES-1, time_out SHALL pulse for 1 cycle, the partial frame SHALL be discarded and the FSM SHALL go to IDLE.
REQ-024 The FIFO SHALL hold FIFO_DEPTH entries with wrap-around pointers and an occupancy count.
REQ-025 fifo_full SHALL equal (count == FIFO_DEPTH).
REQ-026 A push while full with no simultaneous pop SHALL be dropped: overflow pulses 1 cycle and FIFO contents are unchanged.
REQ-027 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; count is unchanged.
REQ-028 A frame pushed at cycle N SHALL be visible on the cmd_* outputs at cycle N+1 when the FIFO was empty.
REQ-029 When the FIFO is non-empty, cmd_* SHALL present the FIFO head and cmd_valid SHALL be 1.
REQ-030 When the FIFO is empty, cmd_* SHALL present a default poll: cmd_op=01, cmd_reg_addr=0x00, cmd_data=0, cmd_from_pc=0, cmd_sensor=poll_idx, and cmd_valid=1.
REQ-031 poll_idx SHALL increment modulo NUM_SENSORS only when a default command transfers.
REQ-032 PC commands SHALL always take priority over the default poll.
REQ-033 The cmd_* outputs SHALL hold stable while cmd_valid=1 and cmd_ready=0, except that a default offer SHALL be replaced by a PC command as soon as the FIFO becomes non-empty.

Reset
REQ-034 While reset=0 at a clk edge, the block SHALL set: FSM to IDLE, FIFO empty, poll_idx=0, timeout counter=0, all pulses 0, fifo_full=0, cmd_valid=0 and all cmd_* fields 0.
REQ-035 cmd_valid SHALL first assert on the first clk edge after reset=1 is sampled.
REQ-036 A reset asserted mid-frame SHALL discard the partial frame and all FIFO contents.

Verification
REQ-037 With cmd_ready=0, bytes FF,23,03,34,12,FF -> cmd_valid=1, cmd_sensor=2, cmd_op=3, cmd_reg_addr=0x03, cmd_data=0x1234, cmd_from_pc=1.
REQ-038 With the FIFO empty, NUM_SENSORS=4 and cmd_ready=1 for 5 cycles -> default transfers with cmd_sensor 0,1,2,3,0, cmd_op=01 and cmd_from_pc=0.
REQ-039 Bytes FF,01 followed by no byte for TIMEOUT_CYCLES -> one time_out pulse, nothing pushed, and a following frame FF,01,05,FF is pushed with cmd_reg_addr=0x05.
REQ-040 Bytes FF,00,02,FE -> frame_error pulse, count stays 0; bytes FF,53,... with NUM_SENSORS=4 -> frame_error at the OP byte.
REQ-041 With cmd_ready=0, FIFO_DEPTH valid frames followed by one more -> fifo_full=1 and an overflow pulse; draining yields the first FIFO_DEPTH frames in order.
REQ-042 Reset=0 after FF,02,10 -> all outputs 0; after release, FF,01,07,FF is parsed normally.
